// File: rtl/lock_key_loader.sv
// lock_key_loader
// Receives a KEY_W-bit unlock key as a serial bitstream (LSB first) over a
// valid/ready handshake, followed by one even-parity bit. The key reaches the
// locked core's key pins only after a complete, parity-clean load; at all
// other times key_out is zero so the core behaves as locked.

module lock_key_loader #(
    parameter int KEY_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             zeroize,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_armed,
    output logic             key_err,
    output logic             busy
);

    localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    // Idle counter must be able to hold TIMEOUT itself; keep one bit when disabled.
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PARITY,
        S_ARMED,
        S_ERROR
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic [KEY_W-1:0]   r_shreg;
    logic [KEY_W-1:0]   r_key_out;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [KEY_W-1:0]   w_shreg_nxt;
    logic [KEY_W-1:0]   w_key_nxt;

    logic               w_beat;
    logic [TMO_W-1:0]   w_tmo_idle;
    logic               w_tmo_hit;
    logic               w_parity_ok;

    // Ready is a pure decode of state so it can never loop back through ser_valid.
    assign ser_ready = (r_state == S_LOAD) || (r_state == S_PARITY);
    assign busy      = ser_ready;
    assign key_armed = (r_state == S_ARMED);
    assign key_err   = (r_state == S_ERROR);
    assign key_out   = r_key_out;

    assign w_beat = ser_valid && ser_ready;

    // Idle-cycle count after one more beat-less cycle; saturates and stays at 0 when disabled.
    assign w_tmo_idle  = ((TIMEOUT == 0) || (r_tmo == TMO_MAX)) ? r_tmo : r_tmo + 1'b1;
    assign w_tmo_hit   = (TIMEOUT != 0) && (w_tmo_idle == TMO_MAX);

    // Even parity over key plus trailing bit must come out zero.
    assign w_parity_ok = ~((^r_shreg) ^ ser_data);

    // Next-state and datapath decode; zeroize outranks start, start outranks beats.
    always_comb begin
        // NOTE: every next-value defaults to "hold" before any branch, so no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_shreg_nxt = r_shreg;
        w_key_nxt   = r_key_out;

        if (zeroize) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_shreg_nxt = '0;
            w_key_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ARMED, S_ERROR: begin
                    // Leaving ARMED clears the key on the same edge, so a reload never shows the old key.
                    if (start) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = '0;
                        w_tmo_nxt   = '0;
                        w_shreg_nxt = '0;
                        w_key_nxt   = '0;
                    end
                end

                S_LOAD: begin
                    if (w_beat) begin
                        w_shreg_nxt[r_cnt] = ser_data;
                        w_cnt_nxt          = r_cnt + 1'b1;
                        w_tmo_nxt          = '0;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = S_PARITY;
                        end
                    end else begin
                        w_tmo_nxt = w_tmo_idle;
                        if (w_tmo_hit) begin
                            w_state_nxt = S_ERROR;
                            w_key_nxt   = '0;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_beat) begin
                        w_tmo_nxt = '0;
                        if (w_parity_ok) begin
                            w_state_nxt = S_ARMED;
                            w_key_nxt   = r_shreg;
                        end else begin
                            w_state_nxt = S_ERROR;
                            w_key_nxt   = '0;
                        end
                    end else begin
                        w_tmo_nxt = w_tmo_idle;
                        if (w_tmo_hit) begin
                            w_state_nxt = S_ERROR;
                            w_key_nxt   = '0;
                        end
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_key_nxt   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shift register is cleared on reset as well, so no partial key bits survive an abort.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_shreg   <= '0;
            r_key_out <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values together.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tmo     <= w_tmo_nxt;
            r_shreg   <= w_shreg_nxt;
            r_key_out <= w_key_nxt;
        end
    end

endmodule

// File: tb/tb_lock_key_loader.sv
// tb_lock_key_loader
// Drives two loaders in lockstep (TIMEOUT=1024 and TIMEOUT=0) and checks both
// every cycle against a bit-queue model of a key load, plus literal
// expectations at the key points of each scenario.

module tb_lock_key_loader;

    localparam int KEY_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, zeroize, ser_valid, ser_data;

    logic             rdy   [2];
    logic [KEY_W-1:0] kout  [2];
    logic             armed [2];
    logic             err   [2];
    logic             bsy   [2];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  cmp_en   = 0;

    lock_key_loader #(.KEY_W(KEY_W), .TIMEOUT(1024)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .zeroize(zeroize),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(rdy[0]),
        .key_out(kout[0]), .key_armed(armed[0]), .key_err(err[0]), .busy(bsy[0])
    );

    lock_key_loader #(.KEY_W(KEY_W), .TIMEOUT(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .zeroize(zeroize),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(rdy[1]),
        .key_out(kout[1]), .key_armed(armed[1]), .key_err(err[1]), .busy(bsy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load is "the bits received so far"; once KEY_W+1 bits are in,
    // the key and parity verdict are read straight off the queue.
    bit               m_load [2];
    bit               m_arm  [2];
    bit               m_err  [2];
    logic [KEY_W-1:0] m_key  [2];
    int               m_idle [2];
    bit               m_q    [2][$];

    task automatic model_clear(input int i);
        m_load[i] = 0;
        m_arm[i]  = 0;
        m_err[i]  = 0;
        m_key[i]  = '0;
        m_idle[i] = 0;
        m_q[i].delete();
    endtask

    task automatic model_step(input int i);
        int               tmo;
        int               ones;
        logic [KEY_W-1:0] k;
        tmo = (i == 0) ? 1024 : 0;
        if (!rst_n || zeroize) begin
            model_clear(i);
        end else if (m_load[i]) begin
            if (ser_valid) begin
                m_q[i].push_back(ser_data);
                m_idle[i] = 0;
                if (m_q[i].size() == KEY_W + 1) begin
                    k = '0;
                    for (int j = 0; j < KEY_W; j++) k[j] = m_q[i][j];
                    ones = $countones(k) + int'(m_q[i][KEY_W]);
                    m_load[i] = 0;
                    if (ones % 2 == 0) begin
                        m_arm[i] = 1;
                        m_key[i] = k;
                    end else begin
                        m_err[i] = 1;
                    end
                end
            end else begin
                m_idle[i]++;
                if (tmo > 0 && m_idle[i] >= tmo) begin
                    m_load[i] = 0;
                    m_err[i]  = 1;
                end
            end
        end else if (start) begin
            model_clear(i);
            m_load[i] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("ready%0d", i), 32'(rdy[i]),   32'(m_load[i]));
                check($sformatf("busy%0d", i),  32'(bsy[i]),   32'(m_load[i]));
                check($sformatf("armed%0d", i), 32'(armed[i]), 32'(m_arm[i]));
                check($sformatf("err%0d", i),   32'(err[i]),   32'(m_err[i]));
                check($sformatf("key%0d", i),   kout[i],       m_arm[i] ? m_key[i] : '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_zeroize();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
    endtask

    task automatic send_bit(input bit b, input bit stall);
        int tries;
        bit acc;
        tries = 0;
        acc   = 0;
        while (!acc) begin
            ser_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ser_data  = b;
            acc       = ser_valid && rdy[0];
            tick();
            tries++;
            if (!acc && tries >= 200) begin
                check("beat_accept", 32'(rdy[0]), 32'd1);
                break;
            end
        end
        ser_valid = 1'b0;
    endtask

    task automatic send_key(input logic [KEY_W-1:0] key, input bit p, input bit stall);
        for (int j = 0; j < KEY_W; j++) send_bit(key[j], stall);
        send_bit(p, stall);
    endtask

    logic [KEY_W-1:0] k;
    bit               p;

    initial begin
        rst_n = 1'b0; start = 1'b0; zeroize = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
        tick();
        cmp_en = 1;
        tick();
        check("rst_key",   kout[0], 32'h0);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        check("rst_busy",  32'(bsy[0]), 32'd0);
        check("rst_armed", 32'(armed[0]), 32'd0);
        check("rst_err",   32'(err[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: good load
        pulse_start();
        check("t1_busy", 32'(bsy[0]), 32'd1);
        send_key(32'hA5C3_0F96, 1'b0, 1'b0);
        check("t1_key",   kout[0], 32'hA5C3_0F96);
        check("t1_armed", 32'(armed[0]), 32'd1);
        check("t1_busy0", 32'(bsy[0]), 32'd0);
        check("t1_key_n", kout[1], 32'hA5C3_0F96);

        // 2: bad parity (reload from ARMED first)
        pulse_start();
        check("t2_reload_key", kout[0], 32'h0);
        send_key(32'hA5C3_0F96, 1'b1, 1'b0);
        check("t2_err", 32'(err[0]), 32'd1);
        check("t2_key", kout[0], 32'h0);
        pulse_start();
        check("t2_err_clr", 32'(err[0]), 32'd0);
        check("t2_busy",    32'(bsy[0]), 32'd1);
        do_zeroize();

        // 3: backpressure, then timeout enabled vs disabled
        pulse_start();
        send_key(32'hA5C3_0F96, 1'b0, 1'b1);
        check("t3_key", kout[0], 32'hA5C3_0F96);
        pulse_start();
        for (int j = 0; j < 10; j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (1023) tick();
        check("t3_err_early", 32'(err[0]), 32'd0);
        tick();
        check("t3_err_tmo",  32'(err[0]), 32'd1);
        check("t3_busy_tmo", 32'(bsy[0]), 32'd0);
        repeat (5000) tick();
        check("t3_noto_err",  32'(err[1]), 32'd0);
        check("t3_noto_busy", 32'(bsy[1]), 32'd1);
        do_zeroize();

        // 4: reload from ARMED
        pulse_start();
        send_key(32'hFFFF_FFFF, 1'b0, 1'b0);
        check("t4_key_ff", kout[0], 32'hFFFF_FFFF);
        pulse_start();
        check("t4_key_clr",   kout[0], 32'h0);
        check("t4_armed_clr", 32'(armed[0]), 32'd0);
        send_key(32'h0000_0001, 1'b1, 1'b0);
        check("t4_key_1", kout[0], 32'h0000_0001);

        // 5: zeroize mid-load, zeroize+start, reset while armed
        pulse_start();
        for (int j = 0; j < 17; j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        ser_valid = 1'b1;
        zeroize   = 1'b1;
        tick();
        zeroize   = 1'b0;
        ser_valid = 1'b0;
        check("t5_ready", 32'(rdy[0]), 32'd0);
        check("t5_busy",  32'(bsy[0]), 32'd0);
        check("t5_key",   kout[0], 32'h0);
        start   = 1'b1;
        zeroize = 1'b1;
        tick();
        start   = 1'b0;
        zeroize = 1'b0;
        check("t5_zs_busy", 32'(bsy[0]), 32'd0);
        k = 32'($urandom);
        pulse_start();
        send_key(k, ^k, 1'b0);
        check("t5_armed", 32'(armed[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t5_rst_key", kout[0], 32'h0);
        rst_n = 1'b1;
        tick();

        // 6: ignored inputs
        for (int j = 0; j < 5; j++) begin
            ser_valid = 1'b1;
            ser_data  = 1'($urandom_range(0, 1));
            tick();
        end
        ser_valid = 1'b0;
        check("t6_idle_busy", 32'(bsy[0]), 32'd0);
        k = 32'h3C5A_9601;
        pulse_start();
        send_key(k, ^k, 1'b0);
        for (int j = 0; j < 5; j++) begin
            ser_valid = 1'b1;
            ser_data  = 1'($urandom_range(0, 1));
            tick();
        end
        ser_valid = 1'b0;
        check("t6_armed_key", kout[0], 32'h3C5A_9601);
        k = 32'h1234_5678;
        pulse_start();
        for (int j = 0; j < 5; j++) send_bit(k[j], 1'b0);
        start = 1'b1;
        send_bit(k[5], 1'b0);
        start = 1'b0;
        for (int j = 6; j < KEY_W; j++) send_bit(k[j], 1'b0);
        send_bit(1'b1, 1'b0);
        check("t6_restart_key",   kout[0], 32'h1234_5678);
        check("t6_restart_armed", 32'(armed[0]), 32'd1);

        // Randomized loads with random stalls and random parity
        for (int n = 0; n < 20; n++) begin
            k = 32'($urandom);
            p = 1'($urandom_range(0, 1));
            pulse_start();
            send_key(k, p, 1'($urandom_range(0, 1)));
            check("rnd_key", kout[0], (((^k) ^ p) == 1'b0) ? k : 32'h0);
            repeat ($urandom_range(0, 3)) tick();
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
